// File: rtl/instr_pkg.sv
// Shared definitions for the instrumentation chain:
// run-state encoding and default gate/word sizes.
package instr_pkg;

  typedef enum logic {
    PARADO    = 1'b0,
    CORRIENDO = 1'b1
  } estado_t;

  localparam int CLK_HZ_DEF = 50000000;
  localparam int WIDTH_DEF  = 16;

endpackage

// File: rtl/base_segundo.sv
// Gate-window index counter; emits a one-cycle
// registered tick on the edge leaving the last index.
module base_segundo
  import instr_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  localparam int IW    = $clog2(CLK_HZ) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          contar,
  output logic [IW-1:0] indice,
  output logic          tick
);

  localparam logic [IW-1:0] ULTIMO = IW'(CLK_HZ - 1);

  logic fin;

  assign fin = (indice == ULTIMO);

  always_ff @(posedge clock) begin
    if (reset || !contar) begin
      indice <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= fin;
      indice <= fin ? '0 : indice + IW'(1);
    end
  end

endmodule

// File: rtl/generador_frecuencia.sv
// Phase-accumulator pulse source: numeroActivo
// single-cycle pulses per CLK_HZ-cycle gate window.
module generador_frecuencia
  import instr_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             habilitar,
  input  logic [WIDTH-1:0] numero,
  output logic             Impulso,
  output logic             ImpulsoSeg,
  output logic [WIDTH-1:0] numeroActivo,
  output logic             onda
);

  localparam int AW   = $clog2(CLK_HZ) + 1;
  localparam int NMAX = (CLK_HZ - 1) / 2;
  localparam int CW   = (WIDTH > AW) ? WIDTH : AW;

  localparam logic [AW-1:0] ULTIMO = AW'(CLK_HZ - 1);
  localparam logic [AW:0]   LIMITE = (AW+1)'(CLK_HZ);

  // NMAX always fits in AW bits, so CW never truncates it
  function automatic logic [WIDTH-1:0] recortar(
    input logic [WIDTH-1:0] n
  );
    if (CW'(n) > CW'(NMAX)) return WIDTH'(NMAX);
    return n;
  endfunction

  estado_t       estado;
  logic [AW-1:0] acc;
  logic [AW-1:0] indice;
  logic          pendiente;
  logic          contar;
  logic          ultimo;
  logic [AW:0]   suma;
  logic          desborde;
  logic          dispara;

  assign contar   = (estado == CORRIENDO) && habilitar;
  assign ultimo   = (indice == ULTIMO);
  assign suma     = {1'b0, acc} + (AW+1)'(numeroActivo);
  assign desborde = (suma >= LIMITE);
  assign dispara  = desborde || pendiente;

  base_segundo #(
    .CLK_HZ (CLK_HZ)
  ) u_base (
    .clock  (clock),
    .reset  (reset),
    .contar (contar),
    .indice (indice),
    .tick   (ImpulsoSeg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= PARADO;
      Impulso      <= 1'b0;
      onda         <= 1'b0;
      numeroActivo <= '0;
      acc          <= '0;
      pendiente    <= 1'b0;
    end else begin
      unique case (estado)
        PARADO: begin
          Impulso      <= 1'b0;
          onda         <= 1'b0;
          acc          <= '0;
          pendiente    <= 1'b0;
          numeroActivo <= '0;
          if (habilitar) begin
            estado       <= CORRIENDO;
            numeroActivo <= recortar(numero);
          end
        end
        CORRIENDO: begin
          if (!habilitar) begin
            estado       <= PARADO;
            Impulso      <= 1'b0;
            onda         <= 1'b0;
            numeroActivo <= '0;
            acc          <= '0;
            pendiente    <= 1'b0;
          end else if (ultimo) begin
            // gate tick owns this slot; hold the pulse
            numeroActivo <= recortar(numero);
            acc          <= '0;
            Impulso      <= 1'b0;
            pendiente    <= desborde;
          end else begin
            acc <= desborde
                 ? AW'(suma - LIMITE)
                 : AW'(suma);
            Impulso   <= dispara;
            onda      <= onda ^ dispara;
            pendiente <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_frecuencia.sv
// Directed bench: per-segment pulse counts/positions
// plus an exact-position check of the first windows.
module tb_generador_frecuencia;

  localparam int CLK_HZ = 20;
  localparam int WIDTH  = 16;

  logic             clock;
  logic             reset;
  logic             habilitar;
  logic [WIDTH-1:0] numero;
  logic             Impulso;
  logic             ImpulsoSeg;
  logic [WIDTH-1:0] numeroActivo;
  logic             onda;

  generador_frecuencia #(
    .CLK_HZ (CLK_HZ),
    .WIDTH  (WIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .habilitar    (habilitar),
    .numero       (numero),
    .Impulso      (Impulso),
    .ImpulsoSeg   (ImpulsoSeg),
    .numeroActivo (numeroActivo),
    .onda         (onda)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        hab;
    logic [15:0] num;
    int          ncyc;
    int          imp;
    int          seg;
    int          imp1;
    int          seg1;
    logic [15:0] na;
    logic        onda;
  } vec_t;

  localparam int NV = 25;

  vec_t tv [NV];
  int   compared;
  int   mism;
  logic prev_imp;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    compared++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    chk("coincide", int'(Impulso && ImpulsoSeg), 0);
    chk("back2back", int'(Impulso && prev_imp), 0);
    prev_imp = Impulso;
  endtask

  initial begin
    int ip [5];
    int c_imp;
    int c_seg;
    int f_imp;
    int f_seg;
    logic e_imp;

    compared  = 0;
    mism      = 0;
    prev_imp  = 1'b0;
    reset     = 1'b1;
    habilitar = 1'b0;
    numero    = '0;

    // rst hab num ncyc | imp seg imp1 seg1 na onda
    tv[0]  = '{1,0, 0, 2, 0,0,0, 0, 0,0};
    tv[1]  = '{0,1, 3, 1, 0,0,0, 0, 3,0};
    tv[2]  = '{0,1, 3,20, 2,1,7,20, 3,0};
    tv[3]  = '{0,1, 3,20, 3,1,1,20, 3,1};
    tv[4]  = '{0,1, 3, 8, 2,0,1, 0, 3,1};
    tv[5]  = '{0,1, 5,12, 1,1,6,12, 5,0};
    tv[6]  = '{0,1, 5,20, 5,1,1,20, 5,1};
    tv[7]  = '{0,1,15,20, 5,1,1,20, 9,0};
    tv[8]  = '{0,1,15,20, 9,1,1,20, 9,1};
    tv[9]  = '{0,1,15,20, 9,1,1,20, 9,0};
    tv[10] = '{0,1, 0,20, 9,1,1,20, 0,1};
    tv[11] = '{0,1, 0,20, 1,1,1,20, 0,0};
    tv[12] = '{0,1, 0,40, 0,2,0,20, 0,0};
    tv[13] = '{0,1, 3,20, 0,1,0,20, 3,0};
    tv[14] = '{0,1, 3,20, 2,1,7,20, 3,0};
    tv[15] = '{0,0, 3, 1, 0,0,0, 0, 0,0};
    tv[16] = '{0,0, 3, 3, 0,0,0, 0, 0,0};
    tv[17] = '{0,1, 3, 1, 0,0,0, 0, 3,0};
    tv[18] = '{0,1, 3,20, 2,1,7,20, 3,0};
    tv[19] = '{0,1, 3,20, 3,1,1,20, 3,1};
    tv[20] = '{0,1, 3,10, 2,0,1, 0, 3,1};
    tv[21] = '{1,1, 3, 1, 0,0,0, 0, 0,0};
    tv[22] = '{0,1, 3, 1, 0,0,0, 0, 3,0};
    tv[23] = '{0,1, 3,20, 2,1,7,20, 3,0};
    tv[24] = '{0,1, 3,20, 3,1,1,20, 3,1};

    for (int k = 0; k < NV; k++) begin
      reset     = tv[k].rst;
      habilitar = tv[k].hab;
      numero    = tv[k].num;
      c_imp = 0;
      c_seg = 0;
      f_imp = 0;
      f_seg = 0;
      for (int c = 1; c <= tv[k].ncyc; c++) begin
        step();
        if (Impulso) begin
          c_imp++;
          if (f_imp == 0) f_imp = c;
        end
        if (ImpulsoSeg) begin
          c_seg++;
          if (f_seg == 0) f_seg = c;
        end
      end
      chk($sformatf("v%0d imp_count", k),
          c_imp, tv[k].imp);
      chk($sformatf("v%0d seg_count", k),
          c_seg, tv[k].seg);
      chk($sformatf("v%0d imp_first", k),
          f_imp, tv[k].imp1);
      chk($sformatf("v%0d seg_first", k),
          f_seg, tv[k].seg1);
      chk($sformatf("v%0d numeroActivo", k),
          int'(numeroActivo), int'(tv[k].na));
      chk($sformatf("v%0d onda", k),
          int'(onda), int'(tv[k].onda));
    end

    // exact cycle positions over two windows, numero=3
    reset     = 1'b1;
    habilitar = 1'b0;
    numero    = 16'd3;
    step();
    step();
    reset     = 1'b0;
    habilitar = 1'b1;
    step();
    ip = '{7, 14, 21, 27, 34};
    for (int c = 1; c <= 40; c++) begin
      step();
      e_imp = 1'b0;
      for (int j = 0; j < 5; j++)
        if (ip[j] == c) e_imp = 1'b1;
      chk($sformatf("pos imp c%0d", c),
          int'(Impulso), int'(e_imp));
      chk($sformatf("pos seg c%0d", c),
          int'(ImpulsoSeg),
          int'(c == 20 || c == 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
